// File: rtl/mem_stage_pkg.sv
// Shared widths, aluop codes, FSM states and op decode for the memory stage.
// Define MEM_LWLR_EN to decode LWL/LWR/SWL/SWR as memory operations.
package mem_stage_pkg;

    localparam int REG_W      = 32;
    localparam int REG_ADDR_W = 5;
    localparam int ALUOP_W    = 8;

    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    localparam logic [ALUOP_W-1:0] EXE_NOP_OP = 8'b0000_0000;
    localparam logic [ALUOP_W-1:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [ALUOP_W-1:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [ALUOP_W-1:0] EXE_LWL_OP = 8'b1110_0010;
    localparam logic [ALUOP_W-1:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [ALUOP_W-1:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [ALUOP_W-1:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [ALUOP_W-1:0] EXE_LWR_OP = 8'b1110_0110;
    localparam logic [ALUOP_W-1:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [ALUOP_W-1:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [ALUOP_W-1:0] EXE_SWL_OP = 8'b1110_1010;
    localparam logic [ALUOP_W-1:0] EXE_SW_OP  = 8'b1110_1011;
    localparam logic [ALUOP_W-1:0] EXE_SWR_OP = 8'b1110_1110;

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_t;

    typedef enum logic [2:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_LEFT, SZ_RIGHT} acc_size_t;

    typedef struct packed {
        logic      is_mem;
        logic      is_load;
        logic      no_wb;   // partial-word op in a build without support: never writes back
        acc_size_t size;
    } op_info_t;

    function automatic op_info_t decode_op(input logic [ALUOP_W-1:0] aluop);
        op_info_t info;
        info.is_mem  = 1'b0;
        info.is_load = 1'b0;
        info.no_wb   = 1'b0;
        info.size    = SZ_WORD;
        case (aluop)
            EXE_LB_OP, EXE_LBU_OP: begin
                info.is_mem = 1'b1; info.is_load = 1'b1; info.size = SZ_BYTE;
            end
            EXE_LH_OP, EXE_LHU_OP: begin
                info.is_mem = 1'b1; info.is_load = 1'b1; info.size = SZ_HALF;
            end
            EXE_LW_OP: begin
                info.is_mem = 1'b1; info.is_load = 1'b1; info.size = SZ_WORD;
            end
            EXE_SB_OP: begin info.is_mem = 1'b1; info.size = SZ_BYTE; end
            EXE_SH_OP: begin info.is_mem = 1'b1; info.size = SZ_HALF; end
            EXE_SW_OP: begin info.is_mem = 1'b1; info.size = SZ_WORD; end
`ifdef MEM_LWLR_EN
            EXE_LWL_OP: begin
                info.is_mem = 1'b1; info.is_load = 1'b1; info.size = SZ_LEFT;
            end
            EXE_LWR_OP: begin
                info.is_mem = 1'b1; info.is_load = 1'b1; info.size = SZ_RIGHT;
            end
            EXE_SWL_OP: begin info.is_mem = 1'b1; info.size = SZ_LEFT; end
            EXE_SWR_OP: begin info.is_mem = 1'b1; info.size = SZ_RIGHT; end
`else
            EXE_LWL_OP, EXE_LWR_OP, EXE_SWL_OP, EXE_SWR_OP: info.no_wb = 1'b1;
`endif
            default: info.is_mem = 1'b0;
        endcase
        return info;
    endfunction

    // Partial-word (left/right) accesses are never misaligned by construction.
    function automatic logic misaligned(input acc_size_t size, input logic [1:0] a);
        return ((size == SZ_HALF) && a[0]) || ((size == SZ_WORD) && (a != 2'b00));
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: byte/half lane select with sign/zero extension, plus LWL/LWR merge.
// Purely combinational; the LWL/LWR merge exists only when MEM_LWLR_EN is defined.
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [ALUOP_W-1:0] aluop,
    input  logic [1:0]         addr_lo,
    input  logic [REG_W-1:0]   rdata,
    input  logic [REG_W-1:0]   reg2,
    output logic [REG_W-1:0]   data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Big-endian: the lowest address holds the most significant byte.
    always_comb begin
        case (addr_lo)
            2'b00:   byte_v = rdata[31:24];
            2'b01:   byte_v = rdata[23:16];
            2'b10:   byte_v = rdata[15:8];
            default: byte_v = rdata[7:0];
        endcase
        half_v = addr_lo[1] ? rdata[15:0] : rdata[31:16];
    end

    always_comb begin
        data_o = rdata;
        case (aluop)
            EXE_LB_OP:  data_o = {{24{byte_v[7]}}, byte_v};
            EXE_LBU_OP: data_o = {24'h0, byte_v};
            EXE_LH_OP:  data_o = {{16{half_v[15]}}, half_v};
            EXE_LHU_OP: data_o = {16'h0, half_v};
`ifdef MEM_LWLR_EN
            EXE_LWL_OP: begin
                case (addr_lo)
                    2'b00:   data_o = rdata;
                    2'b01:   data_o = {rdata[23:0], reg2[7:0]};
                    2'b10:   data_o = {rdata[15:0], reg2[15:0]};
                    default: data_o = {rdata[7:0], reg2[23:0]};
                endcase
            end
            EXE_LWR_OP: begin
                case (addr_lo)
                    2'b00:   data_o = {reg2[31:8], rdata[31:24]};
                    2'b01:   data_o = {reg2[31:16], rdata[31:16]};
                    2'b10:   data_o = {reg2[31:24], rdata[31:8]};
                    default: data_o = rdata;
                endcase
            end
`endif
            default: data_o = rdata;
        endcase
    end

`ifndef MEM_LWLR_EN
    logic unused_reg2;
    assign unused_reg2 = ^reg2;
`endif

endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: issues one data-bus access per load/store and stalls the pipe until ack or timeout.
// Define MEM_LWLR_EN to support LWL/LWR/SWL/SWR; TIMEOUT=0 waits forever for dbus_ack.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            stall,
    input  logic [REG_ADDR_W-1:0] mem_wd,
    input  logic                  mem_wreg,
    input  logic [REG_W-1:0]      mem_wdata,
    input  logic [REG_W-1:0]      mem_hi,
    input  logic [REG_W-1:0]      mem_lo,
    input  logic                  mem_whilo,
    input  logic [ALUOP_W-1:0]    mem_aluop,
    input  logic [REG_W-1:0]      mem_mem_addr,
    input  logic [REG_W-1:0]      mem_reg2,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [REG_W-1:0]      wdata_o,
    output logic [REG_W-1:0]      hi_o,
    output logic [REG_W-1:0]      lo_o,
    output logic                  whilo_o,
    output logic                  dbus_req,
    output logic                  dbus_we,
    output logic [REG_W-1:0]      dbus_addr,
    output logic [3:0]            dbus_sel,
    output logic [REG_W-1:0]      dbus_wdata,
    input  logic                  dbus_ack,
    input  logic [REG_W-1:0]      dbus_rdata,
    output logic                  stallreq,
    output logic                  addr_err_o,
    output logic                  bus_err_o
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    op_info_t         info;
    logic [1:0]       a_lo;
    logic             addr_err;
    logic             go;
    logic [3:0]       sel_c;
    logic [REG_W-1:0] wdat_c;
    logic [REG_W-1:0] ld_data;
    logic             timeout_hit;

    state_t           state_q, state_d;
    logic             dbus_req_q, dbus_req_d;
    logic             dbus_we_q, dbus_we_d;
    logic [REG_W-1:0] dbus_addr_q, dbus_addr_d;
    logic [3:0]       dbus_sel_q, dbus_sel_d;
    logic [REG_W-1:0] dbus_wdata_q, dbus_wdata_d;
    logic [REG_W-1:0] data_q, data_d;
    logic             ld_q, ld_d;
    logic             abort_q, abort_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign info     = decode_op(mem_aluop);
    assign a_lo     = mem_mem_addr[1:0];
    assign addr_err = info.is_mem && misaligned(info.size, a_lo);
    assign go       = info.is_mem && !addr_err;

    always_comb begin
        sel_c  = 4'b0000;
        wdat_c = mem_reg2;
        case (info.size)
            SZ_BYTE: begin
                wdat_c = {4{mem_reg2[7:0]}};
                case (a_lo)
                    2'b00:   sel_c = 4'b1000;
                    2'b01:   sel_c = 4'b0100;
                    2'b10:   sel_c = 4'b0010;
                    default: sel_c = 4'b0001;
                endcase
            end
            SZ_HALF: begin
                wdat_c = {2{mem_reg2[15:0]}};
                sel_c  = a_lo[1] ? 4'b0011 : 4'b1100;
            end
            SZ_WORD: sel_c = 4'b1111;
`ifdef MEM_LWLR_EN
            // Left/right loads fetch the whole word and merge in mem_load_align.
            SZ_LEFT: begin
                case (a_lo)
                    2'b00:   begin sel_c = 4'b1111; wdat_c = mem_reg2; end
                    2'b01:   begin sel_c = 4'b0111; wdat_c = {8'h0, mem_reg2[31:8]}; end
                    2'b10:   begin sel_c = 4'b0011; wdat_c = {16'h0, mem_reg2[31:16]}; end
                    default: begin sel_c = 4'b0001; wdat_c = {24'h0, mem_reg2[31:24]}; end
                endcase
                if (info.is_load) sel_c = 4'b1111;
            end
            SZ_RIGHT: begin
                case (a_lo)
                    2'b00:   begin sel_c = 4'b1000; wdat_c = {mem_reg2[7:0], 24'h0}; end
                    2'b01:   begin sel_c = 4'b1100; wdat_c = {mem_reg2[15:0], 16'h0}; end
                    2'b10:   begin sel_c = 4'b1110; wdat_c = {mem_reg2[23:0], 8'h0}; end
                    default: begin sel_c = 4'b1111; wdat_c = mem_reg2; end
                endcase
                if (info.is_load) sel_c = 4'b1111;
            end
`endif
            default: sel_c = 4'b0000;
        endcase
    end

    mem_load_align u_load_align (
        .aluop   (mem_aluop),
        .addr_lo (a_lo),
        .rdata   (dbus_rdata),
        .reg2    (mem_reg2),
        .data_o  (ld_data)
    );

    // Ack wins over timeout when both land in the same cycle.
    assign timeout_hit = (TIMEOUT > 0) && (state_q == ST_ACCESS) && !dbus_ack
                         && (cnt_q == CNT_W'(TIMEOUT));

    always_comb begin
        state_d      = state_q;
        dbus_req_d   = dbus_req_q;
        dbus_we_d    = dbus_we_q;
        dbus_addr_d  = dbus_addr_q;
        dbus_sel_d   = dbus_sel_q;
        dbus_wdata_d = dbus_wdata_q;
        data_d       = data_q;
        ld_d         = ld_q;
        abort_d      = abort_q;
        cnt_d        = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    state_d      = ST_ACCESS;
                    dbus_req_d   = 1'b1;
                    dbus_we_d    = !info.is_load;
                    dbus_addr_d  = {mem_mem_addr[REG_W-1:2], 2'b00};
                    dbus_sel_d   = sel_c;
                    dbus_wdata_d = wdat_c;
                    ld_d         = info.is_load;
                    abort_d      = 1'b0;
                    cnt_d        = '0;
                end
            end
            ST_ACCESS: begin
                if (dbus_ack) begin
                    state_d    = ST_DONE;
                    data_d     = ld_data;
                    dbus_req_d = 1'b0;
                    dbus_we_d  = 1'b0;
                    dbus_sel_d = 4'b0000;
                end else if (timeout_hit) begin
                    state_d    = ST_DONE;
                    abort_d    = 1'b1;
                    dbus_req_d = 1'b0;
                    dbus_we_d  = 1'b0;
                    dbus_sel_d = 4'b0000;
                end else if (TIMEOUT > 0) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (!stall[4]) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            dbus_req_q   <= 1'b0;
            dbus_we_q    <= 1'b0;
            dbus_addr_q  <= '0;
            dbus_sel_q   <= 4'b0000;
            dbus_wdata_q <= '0;
            data_q       <= '0;
            ld_q         <= 1'b0;
            abort_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            dbus_req_q   <= dbus_req_d;
            dbus_we_q    <= dbus_we_d;
            dbus_addr_q  <= dbus_addr_d;
            dbus_sel_q   <= dbus_sel_d;
            dbus_wdata_q <= dbus_wdata_d;
            data_q       <= data_d;
            ld_q         <= ld_d;
            abort_q      <= abort_d;
            cnt_q        <= cnt_d;
        end
    end

    assign dbus_req   = dbus_req_q;
    assign dbus_we    = dbus_we_q;
    assign dbus_addr  = dbus_addr_q;
    assign dbus_sel   = dbus_sel_q;
    assign dbus_wdata = dbus_wdata_q;

    assign stallreq = !rst && (((state_q == ST_IDLE) && go) || (state_q == ST_ACCESS));

    always_comb begin
        wd_o       = mem_wd;
        wreg_o     = mem_wreg;
        wdata_o    = mem_wdata;
        hi_o       = mem_hi;
        lo_o       = mem_lo;
        whilo_o    = mem_whilo;
        addr_err_o = 1'b0;
        bus_err_o  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (info.no_wb || go) wreg_o = WRITE_DISABLE;
                if (addr_err) begin
                    addr_err_o = 1'b1;
                    wreg_o     = WRITE_DISABLE;
                end
            end
            ST_ACCESS: begin
                wreg_o    = WRITE_DISABLE;
                bus_err_o = timeout_hit;
            end
            ST_DONE: begin
                if (abort_q || !ld_q) wreg_o = WRITE_DISABLE;
                else                  wdata_o = data_q;
            end
            default: wreg_o = WRITE_DISABLE;
        endcase
        if (rst) begin
            wd_o       = '0;
            wreg_o     = WRITE_DISABLE;
            wdata_o    = '0;
            hi_o       = '0;
            lo_o       = '0;
            whilo_o    = 1'b0;
            addr_err_o = 1'b0;
            bus_err_o  = 1'b0;
        end
    end

    logic unused_stall;
    assign unused_stall = ^{stall[5], stall[3:0]};

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage (TIMEOUT=4): loads, stores, extension, misalignment, timeout, reset.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam logic [7:0] ALU_ADD = 8'b0010_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata, mem_hi, mem_lo;
    logic        mem_whilo;
    logic [7:0]  mem_aluop;
    logic [31:0] mem_mem_addr, mem_reg2;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o, hi_o, lo_o;
    logic        whilo_o;
    logic        dbus_req, dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_sel;
    logic [31:0] dbus_wdata;
    logic        dbus_ack;
    logic [31:0] dbus_rdata;
    logic        stallreq, addr_err_o, bus_err_o;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
        .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .hi_o(hi_o), .lo_o(lo_o),
        .whilo_o(whilo_o), .dbus_req(dbus_req), .dbus_we(dbus_we),
        .dbus_addr(dbus_addr), .dbus_sel(dbus_sel), .dbus_wdata(dbus_wdata),
        .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata), .stallreq(stallreq),
        .addr_err_o(addr_err_o), .bus_err_o(bus_err_o)
    );

    int n_checks = 0;
    int n_errs   = 0;
    int stalls, err_cyc, err_pulses;
    logic        snap_req, snap_we;
    logic [31:0] snap_addr, snap_wdata;
    logic [3:0]  snap_sel;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a memory op and follows it to the first non-stalled cycle; ack_at=0 never acks.
    task automatic run_mem(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                           input int ack_at, input logic [31:0] rdata);
        stalls = 0; err_cyc = -1; err_pulses = 0;
        snap_req = 1'b0; snap_we = 1'b0; snap_addr = '0; snap_sel = '0; snap_wdata = '0;
        mem_aluop = op; mem_mem_addr = addr; mem_reg2 = reg2;
        mem_wreg = 1'b1; mem_wd = 5'd9; mem_wdata = 32'h0BAD_0BAD;
        #1;
        for (int c = 0; c < 20; c++) begin
            if (!stallreq) break;
            stalls++;
            if (bus_err_o) begin err_pulses++; err_cyc = c; end
            if (c == 1) begin
                snap_req = dbus_req; snap_we = dbus_we; snap_addr = dbus_addr;
                snap_sel = dbus_sel; snap_wdata = dbus_wdata;
            end
            tick();
            dbus_ack   = (ack_at != 0) && (c + 1 == ack_at);
            dbus_rdata = dbus_ack ? rdata : 32'hA5A5_A5A5;
            #1;
        end
        dbus_ack = 1'b0;
    endtask

    task automatic retire();
        tick();
        mem_aluop = EXE_NOP_OP; mem_wreg = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 6'b0; dbus_ack = 1'b0; dbus_rdata = 32'h0;
        mem_wd = 5'h1F; mem_wreg = 1'b1; mem_wdata = 32'hFFFF_FFFF;
        mem_hi = 32'h1111_1111; mem_lo = 32'h2222_2222; mem_whilo = 1'b1;
        mem_aluop = ALU_ADD; mem_mem_addr = 32'h0; mem_reg2 = 32'h0;

        tick(); tick(); #1;
        check("rst_wd", wd_o, 0);
        check("rst_wreg", wreg_o, 0);
        check("rst_wdata", wdata_o, 0);
        check("rst_hi", hi_o, 0);
        check("rst_lo", lo_o, 0);
        check("rst_whilo", whilo_o, 0);
        check("rst_req", dbus_req, 0);
        check("rst_we", dbus_we, 0);
        check("rst_sel", dbus_sel, 0);
        check("rst_buserr", bus_err_o, 0);

        tick();
        rst = 1'b0; mem_wd = 5'h15; mem_wdata = 32'hDEAD_BEEF;
        #1;
        check("pass_wd", wd_o, 32'h15);
        check("pass_wreg", wreg_o, 1);
        check("pass_wdata", wdata_o, 32'hDEAD_BEEF);
        check("pass_hi", hi_o, 32'h1111_1111);
        check("pass_whilo", whilo_o, 1);
        check("pass_stall", stallreq, 0);
        check("pass_req", dbus_req, 0);

        tick();
        run_mem(EXE_LW_OP, 32'h100, 32'h0, 3, 32'h1234_5678);
        check("lw_stalls", stalls, 4);
        check("lw_req", snap_req, 1);
        check("lw_addr", snap_addr, 32'h100);
        check("lw_sel", snap_sel, 4'b1111);
        check("lw_we", snap_we, 0);
        check("lw_wdata_o", wdata_o, 32'h1234_5678);
        check("lw_wreg_o", wreg_o, 1);
        check("lw_req_done", dbus_req, 0);
        retire();

        run_mem(EXE_LB_OP, 32'h103, 32'h0, 1, 32'h0000_00F0);
        check("lb_stalls", stalls, 2);
        check("lb_sel", snap_sel, 4'b0001);
        check("lb_addr", snap_addr, 32'h100);
        check("lb_wdata_o", wdata_o, 32'hFFFF_FFF0);
        stall = 6'b01_0000;
        tick(); #1;
        check("lb_hold_wdata", wdata_o, 32'hFFFF_FFF0);
        check("lb_hold_stallreq", stallreq, 0);
        check("lb_hold_req", dbus_req, 0);
        stall = 6'b0;
        retire();

        run_mem(EXE_LBU_OP, 32'h103, 32'h0, 1, 32'h0000_00F0);
        check("lbu_wdata_o", wdata_o, 32'h0000_00F0);
        retire();

        run_mem(EXE_LH_OP, 32'h102, 32'h0, 2, 32'h1234_8001);
        check("lh_sel", snap_sel, 4'b0011);
        check("lh_wdata_o", wdata_o, 32'hFFFF_8001);
        retire();

        run_mem(EXE_LHU_OP, 32'h100, 32'h0, 1, 32'h8001_7777);
        check("lhu_sel", snap_sel, 4'b1100);
        check("lhu_wdata_o", wdata_o, 32'h0000_8001);
        retire();

        run_mem(EXE_SH_OP, 32'h102, 32'h0000_ABCD, 2, 32'h0);
        check("sh_stalls", stalls, 3);
        check("sh_sel", snap_sel, 4'b0011);
        check("sh_wdata", snap_wdata, 32'hABCD_ABCD);
        check("sh_we", snap_we, 1);
        check("sh_wreg_o", wreg_o, 0);
        retire();

        run_mem(EXE_SB_OP, 32'h101, 32'h0000_003C, 1, 32'h0);
        check("sb_sel", snap_sel, 4'b0100);
        check("sb_wdata", snap_wdata, 32'h3C3C_3C3C);
        retire();

        mem_aluop = EXE_LW_OP; mem_mem_addr = 32'h101; mem_wreg = 1'b1;
        #1;
        check("mis_err", addr_err_o, 1);
        check("mis_stall", stallreq, 0);
        check("mis_wreg", wreg_o, 0);
        tick(); #1;
        check("mis_req1", dbus_req, 0);
        tick(); #1;
        check("mis_req2", dbus_req, 0);
        mem_aluop = EXE_LH_OP; mem_mem_addr = 32'h103;
        #1;
        check("mis_lh_err", addr_err_o, 1);
        retire();

        run_mem(EXE_LW_OP, 32'h200, 32'h0, 0, 32'h0);
        check("to_stalls", stalls, 6);
        check("to_err_cycle", err_cyc, 5);
        check("to_err_pulses", err_pulses, 1);
        check("to_wreg_o", wreg_o, 0);
        check("to_req_done", dbus_req, 0);
        check("to_buserr_done", bus_err_o, 0);
        dbus_ack = 1'b1; dbus_rdata = 32'h5555_5555;
        #1;
        check("to_late_ack_wreg", wreg_o, 0);
        retire();
        dbus_ack = 1'b0;
        check("to_idle_stall", stallreq, 0);
        check("to_idle_req", dbus_req, 0);

        mem_aluop = EXE_LW_OP; mem_mem_addr = 32'h300; mem_wreg = 1'b1;
        mem_wd = 5'd9; mem_wdata = 32'h1111_2222;
        #1;
        check("rsta_idle_stall", stallreq, 1);
        tick(); #1;
        check("rsta_req", dbus_req, 1);
        rst = 1'b1;
        #1;
        check("rsta_wd", wd_o, 0);
        check("rsta_wreg", wreg_o, 0);
        check("rsta_wdata", wdata_o, 0);
        tick();
        rst = 1'b0; mem_aluop = EXE_NOP_OP; dbus_ack = 1'b1; dbus_rdata = 32'hCAFE_F00D;
        #1;
        check("rsta_req_after", dbus_req, 0);
        check("rsta_stall_after", stallreq, 0);
        check("rsta_pass_wdata", wdata_o, 32'h1111_2222);
        tick();
        dbus_ack = 1'b0;
        #1;
        check("rsta_req_late", dbus_req, 0);
        check("rsta_stall_late", stallreq, 0);

        mem_aluop = EXE_LWL_OP; mem_mem_addr = 32'h101; mem_reg2 = 32'h1122_3344; mem_wreg = 1'b1;
`ifdef MEM_LWLR_EN
        run_mem(EXE_LWL_OP, 32'h101, 32'h1122_3344, 1, 32'hAABB_CCDD);
        check("lwl_wdata_o", wdata_o, 32'hBBCC_DD44);
        check("lwl_err", addr_err_o, 0);
        retire();
`else
        #1;
        check("lwl_off_wreg", wreg_o, 0);
        check("lwl_off_stall", stallreq, 0);
        check("lwl_off_err", addr_err_o, 0);
        tick(); #1;
        check("lwl_off_req", dbus_req, 0);
        mem_aluop = EXE_NOP_OP;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

endmodule
